// File: rtl/pe_csa_acc_resolve.sv
// pe_csa_acc_resolve: carry-save group accumulator with a segmented multi-cycle carry-propagate resolve
module pe_csa_acc_resolve #(
  parameter int WIDTH = 109,
  parameter int SEG   = 28,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy
);
  localparam int NSEG  = (WIDTH + SEG - 1) / SEG;
  localparam int LAST  = WIDTH - (NSEG - 1) * SEG;
  localparam int SEG_W = NSEG > 1 ? $clog2(NSEG) : 1;
  typedef enum logic [1:0] {ACC, RESOLVE, OUTPUT} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_acc_s, r_acc_c, r_res;
  logic [CNT_W-1:0] r_cnt;
  logic [SEG_W-1:0] r_seg;
  logic             r_cin, r_in_ready, r_out_valid, r_busy;
  logic [WIDTH-1:0] w_s1, w_c1, w_s2, w_c2;
  logic [SEG:0]     w_sum;
  logic             w_seg_last;
  // 4:2 compression as two 3:2 layers; the adder only ever sees the low segment because the accumulator shifts down while resolving
  always_comb begin
    w_s1       = r_acc_s ^ r_acc_c ^ in_sum;
    w_c1       = ((r_acc_s & r_acc_c) | (r_acc_s & in_sum) | (r_acc_c & in_sum)) << 1;
    w_s2       = w_s1 ^ w_c1 ^ in_carry;
    w_c2       = ((w_s1 & w_c1) | (w_s1 & in_carry) | (w_c1 & in_carry)) << 1;
    w_sum      = {1'b0, r_acc_s[SEG-1:0]} + {1'b0, r_acc_c[SEG-1:0]} + {{SEG{1'b0}}, r_cin};
    w_seg_last = r_seg == SEG_W'(NSEG - 1);
  end
  // group FSM: segments enter the result from the top; the final partial segment shifts by LAST so everything lands aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_acc_s     <= '0;
      r_acc_c     <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_seg       <= '0;
      r_cin       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ACC: if (in_valid) begin
          r_acc_s <= w_s2;
          r_acc_c <= w_c2;
          r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, ~&r_cnt};
          if (in_last) begin
            r_state    <= RESOLVE;
            r_seg      <= '0;
            r_cin      <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RESOLVE: begin
          r_acc_s <= r_acc_s >> SEG;
          r_acc_c <= r_acc_c >> SEG;
          r_cin   <= w_sum[SEG];
          r_seg   <= r_seg + 1'b1;
          r_res   <= w_seg_last ? {w_sum[LAST-1:0], r_res[WIDTH-1:LAST]} : {w_sum[SEG-1:0], r_res[WIDTH-1:SEG]};
          if (w_seg_last) begin
            r_state     <= OUTPUT;
            r_out_valid <= 1'b1;
          end
        end
        OUTPUT: if (out_ready) begin
          r_acc_s     <= '0;
          r_acc_c     <= '0;
          r_cnt       <= '0;
          r_state     <= ACC;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= ACC;
      endcase
    end
  end
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_res;
  assign out_cnt   = r_cnt;
endmodule

// File: tb/tb_pe_csa_acc_resolve.sv
// tb_pe_csa_acc_resolve: directed scoreboard bench for the carry-save accumulator/resolver
module tb_pe_csa_acc_resolve;
  localparam int W = 109;
  localparam int C = 8;
  localparam int NSEG = 4;
  typedef struct packed {logic [W-1:0] d; logic [C-1:0] c;} exp_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_sum = '0, in_carry = '0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] out_data;
  logic [C-1:0] out_cnt;
  exp_t q[$];
  logic [W-1:0] m_sum = '0;
  logic [C-1:0] m_cnt = '0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pe_csa_acc_resolve #(.WIDTH(W), .SEG(28), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_carry(in_carry), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input logic last, input logic rdy_chk);
    int n = 0;
    in_valid = 1'b1;
    in_sum = s;
    in_carry = c;
    in_last = last;
    if (rdy_chk) chk("beat_in_ready", in_ready, 1);
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    tick();
    m_sum = m_sum + s + c;
    m_cnt = (m_cnt == '1) ? m_cnt : m_cnt + 1'b1;
    if (last) begin
      q.push_back({m_sum, m_cnt});
      m_sum = '0;
      m_cnt = '0;
      in_valid = 1'b0;
      in_last = 1'b0;
    end
  endtask

  task automatic get(input int stall, input logic lat_chk);
    int n = 0;
    exp_t e = '0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("out_valid_rise", out_valid, 1);
    if (lat_chk) chk("latency", n, NSEG);
    if (q.size() > 0) e = q.pop_front();
    chk("busy_output", busy, 1);
    chk("in_ready_output", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_sum = W'(100);
      in_carry = '0;
      in_last = 1'b1;
      out_ready = 1'b0;
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, e.d);
      chk("stall_cnt", out_cnt, e.c);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("out_data", out_data, e.d);
    chk("out_cnt", out_cnt, e.c);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    send(W'(5), W'(3), 1'b1, 1'b1);
    get(0, 1'b1);
    send('1, '0, 1'b0, 1'b1);
    send('1, '0, 1'b0, 1'b1);
    send('1, '0, 1'b1, 1'b1);
    get(0, 1'b1);
    send((W'(1) << 28) - 1'b1, W'(1), 1'b1, 1'b0);
    get(0, 1'b1);
    send((W'(1) << 84) - 1'b1, W'(1), 1'b1, 1'b0);
    get(0, 1'b1);
    send(W'(1) << 108, '0, 1'b0, 1'b0);
    send(W'(1) << 108, '0, 1'b1, 1'b0);
    get(0, 1'b1);
    for (int i = 0; i < 300; i++) send(W'(1), '0, i == 299, 1'b0);
    get(0, 1'b1);
    send(W'(9), W'(1), 1'b1, 1'b0);
    get(5, 1'b1);
    send(W'(7), '0, 1'b1, 1'b1);
    get(0, 1'b1);
    send(W'(50), W'(50), 1'b1, 1'b0);
    tick();
    chk("resolve_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_cnt", out_cnt, 0);
    if (q.size() > 0) void'(q.pop_back());
    send(W'(4), W'(4), 1'b1, 1'b1);
    get(0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
